sys_bridge: RTL
===============

// Module: sys_bridge
// PURPOSE
// - Data-side system bridge directly downstream of the CPU core's data port: accepts MEM-stage load/store requests.
// - Decodes each address to one of three targets: external RAM (multi-cycle req/ack), an internal timer device, or unmapped space.
// - Stalls the pipeline until the access completes; drives the timer's hardware interrupt to CP0.
// PARAMETERS
// RAM_BASE       32'h0000_0000  RAM region base; compare addr[31:RAM_AW] to RAM_BASE[31:RAM_AW]
// RAM_AW         14             log2 of RAM region size in bytes
// DEV_BASE       32'h0000_7F00  timer register block base (3 words)
// RAM_TIMEOUT    16             max RAM_WAIT cycles before the access is aborted
// PORTS
// clk            in   1   clock, all state on rising edge
// rst            in   1   synchronous reset, active-low (rst==0 resets)
// cpu_req        in   1   data access valid; CPU holds all cpu_* inputs stable while cpu_stall=1
// cpu_we         in   1   1=store, 0=load
// cpu_addr       in   32  byte address, word aligned
// cpu_wdata      in   32  store data
// cpu_be         in   4   byte enables
// cpu_rdata      out  32  load data, valid when the access completes
// cpu_stall      out  1   freeze pipeline (combinational)
// bus_err        out  1   1-cycle pulse: unmapped access or RAM timeout
// ram_req        out  1   RAM request, held until ram_ack or timeout
// ram_we         out  1   RAM write
// ram_addr       out  32  RAM address (latched)
// ram_wdata      out  32  RAM write data (latched)
// ram_be         out  4   RAM byte enables (latched)
// ram_rdata      in   32  RAM read data, valid with ram_ack
// ram_ack        in   1   RAM completion, single-cycle pulse
// hw_int         out  6   CP0 hardware interrupts; bit 2 = timer, other bits 0
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0, including ram_req/cpu_stall/bus_err/hw_int/cpu_rdata; timer CTRL, PRESET, COUNT and pend all 0.
// - FSM states: IDLE, RAM_WAIT, DONE.
// - IDLE + cpu_req + RAM hit:
//   - latch we/addr/wdata/be; go RAM_WAIT; clear timeout counter.
//   - cpu_stall=1 in this cycle.
// - RAM_WAIT:
//   - ram_req=1, cpu_stall=1, counter increments every cycle.
//   - On ram_ack: register ram_rdata into cpu_rdata (stores: cpu_rdata=0); go DONE.
//   - If the counter reaches RAM_TIMEOUT with no ack: drop ram_req, cpu_rdata=32'hDEAD_BEEF, pulse bus_err, go DONE.
//   - An ack in the same cycle as the timeout: ack wins.
// - DONE: cpu_stall=0 for exactly one cycle so the CPU retires the access; then IDLE.
//   - The request present in DONE is not reissued.
// - IDLE + device hit:
//   - completes in the same cycle, cpu_stall=0.
//   - cpu_rdata combinational from the register file.
//   - The write takes effect at the clock edge.
// - IDLE + unmapped: completes in the same cycle; cpu_rdata=0; bus_err=1 for that cycle; stores are dropped.
// - Timer registers at DEV_BASE offsets:
//   - +0 CTRL: [0]=EN, [2:1]=MODE (00 one-shot, 01 auto-reload, others act as 00), [3]=IM.
//   - +4 PRESET.
//   - +8 COUNT (read-only).
//   - Device writes are honoured only when be==4'hF; partial writes are ignored.
// - Writing PRESET also loads COUNT. Writing CTRL clears pend.
// - While EN=1 and COUNT!=0, COUNT decrements by 1 each cycle. On the 1->0 transition:
//   - pend is set.
//   - MODE 00: EN is cleared.
//   - MODE 01: COUNT reloads PRESET on the next cycle.
// - hw_int[2] = pend & IM, registered.
// - Simultaneous events:
//   - CPU PRESET write in the expiry cycle: the written value loads COUNT; pend is still set.
//   - CTRL write in the expiry cycle: the write wins, pend ends 0.
// - Reset mid-operation (rst=0 in RAM_WAIT): next cycle state=IDLE, ram_req=0, no bus_err; an in-flight ram_ack is ignored.
// TESTING
// - RAM load at 0x100, ram_ack 3 cycles after ram_req -> cpu_stall high 4 cycles, then 1 DONE cycle with cpu_rdata=ram_rdata; ram_req high exactly 3 cycles.
// - RAM store, ack withheld -> after 16 RAM_WAIT cycles: ram_req drops, bus_err pulses once, cpu_rdata=0xDEADBEEF, stall released in DONE.
// - Write PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> COUNT 5,4..0; hw_int[2]=1 the cycle after reaching 0; EN reads 0; CTRL write clears hw_int.
// - MODE 01, PRESET=3 -> pend set every 4 cycles, COUNT reloads 3; PRESET write with be=4'h3 leaves PRESET unchanged.
// - Load from 0x8000_0000 -> no stall, cpu_rdata=0, bus_err 1 cycle, ram_req never asserted.
// - rst=0 during RAM_WAIT with ram_ack arriving next cycle -> state IDLE, ram_req=0, cpu_rdata=0, no spurious DONE.

Source files
------------

// File: rtl/sys_bridge.sv
// sys_bridge: data-side bridge from the CPU MEM stage to RAM, a timer and unmapped space.
// RAM accesses stall the pipeline; the timer raises hw_int[2] towards CP0.
module sys_bridge #(
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter int          RAM_AW      = 14,
  parameter logic [31:0] DEV_BASE    = 32'h0000_7F00,
  parameter int          RAM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_err,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_be,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic [5:0]  hw_int
);

  localparam int CW = $clog2(RAM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RAM_WAIT, DONE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          we_q, err_q, pend, hw_q, tmo;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [31:0]   preset, count, dev_rd;
  logic [3:0]    be_q, ctrl;
  logic          ram_hit, dev_hit, idle_req;
  logic          ram_go, dev_acc, unm;
  logic          sel_ctrl, sel_pre, sel_cnt;
  logic          wr_ctrl, wr_pre, auto, expire;

  assign ram_hit  = cpu_addr[31:RAM_AW] == RAM_BASE[31:RAM_AW];
  assign sel_ctrl = cpu_addr == DEV_BASE;
  assign sel_pre  = cpu_addr == DEV_BASE + 32'd4;
  assign sel_cnt  = cpu_addr == DEV_BASE + 32'd8;
  assign dev_hit  = sel_ctrl | sel_pre | sel_cnt;

  assign idle_req = (state == IDLE) & cpu_req;
  assign ram_go   = idle_req & ram_hit;
  assign dev_acc  = idle_req & ~ram_hit & dev_hit;
  assign unm      = idle_req & ~ram_hit & ~dev_hit;

  // partial-width device stores are ignored
  assign wr_ctrl = dev_acc & cpu_we & (cpu_be == 4'hF) & sel_ctrl;
  assign wr_pre  = dev_acc & cpu_we & (cpu_be == 4'hF) & sel_pre;
  assign auto    = ctrl[2:1] == 2'b01;
  assign expire  = ctrl[0] & (count == 32'd1);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    ram_req   = 1'b0;
    cpu_stall = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (ram_go) begin
          cpu_stall = 1'b1;
          cnt_d     = '0;
          state_d   = RAM_WAIT;
        end
      end
      RAM_WAIT: begin
        ram_req   = 1'b1;
        cpu_stall = 1'b1;
        cnt_d     = cnt + CW'(1);
        if (ram_ack) begin
          state_d = DONE;
        end else if (cnt == CW'(RAM_TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dev_rd = '0;
    unique case (1'b1)
      sel_ctrl: dev_rd = {28'd0, ctrl};
      sel_pre:  dev_rd = preset;
      sel_cnt:  dev_rd = count;
      default:  dev_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      err_q <= tmo;
      if (ram_go) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        be_q    <= cpu_be;
      end
      if (state == RAM_WAIT) begin
        if (ram_ack)  rdata_q <= we_q ? 32'd0 : ram_rdata;
        else if (tmo) rdata_q <= 32'hDEAD_BEEF;
      end
    end
  end

  // later assignments win: CPU writes override same-cycle timer updates
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      pend   <= 1'b0;
      hw_q   <= 1'b0;
    end else begin
      hw_q <= pend & ctrl[3];
      if (ctrl[0] && count != 32'd0) count <= count - 32'd1;
      else if (ctrl[0] && auto)      count <= preset;
      if (expire) begin
        pend <= 1'b1;
        if (!auto) ctrl[0] <= 1'b0;
      end
      if (wr_pre) begin
        preset <= cpu_wdata;
        count  <= cpu_wdata;
      end
      if (wr_ctrl) begin
        ctrl <= cpu_wdata[3:0];
        pend <= 1'b0;
      end
    end
  end

  assign cpu_rdata = dev_acc ? dev_rd : (state == DONE) ? rdata_q : 32'd0;
  assign bus_err   = unm | ((state == DONE) & err_q);
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_be    = be_q;
  assign hw_int    = {3'b000, hw_q, 2'b00};

endmodule
